// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : Serialised LD/SD memory-stage responder with fixed access latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] element1,
    input  logic [63:0] element2,
    input  logic [63:0] element3,
    input  logic [63:0] element4,
    input  logic [63:0] element5,
    input  logic [63:0] element6,
    input  logic [63:0] element7,
    input  logic [63:0] element8,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] addr,
    input  logic [63:0] write_data,
    input  logic        flush,
    output logic [63:0] read_data,
    output logic        resp_valid,
    output logic        err,
    output logic        stall
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               store_q, store_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [63:0]        wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [63:0]        read_data_q;
    logic [63:0]        mem_q [DEPTH];

    logic               w_req;
    logic               w_valid;
    logic               w_mem_we;
    logic               w_load_en;
    logic [63:0]        w_elem [8];

    assign w_elem[0] = element1;
    assign w_elem[1] = element2;
    assign w_elem[2] = element3;
    assign w_elem[3] = element4;
    assign w_elem[4] = element5;
    assign w_elem[5] = element6;
    assign w_elem[6] = element7;
    assign w_elem[7] = element8;

    assign w_req   = mem_read | mem_write;
    assign w_valid = (mem_read ^ mem_write) && (addr[2:0] == 3'b000) &&
                     (addr[63:3] < 61'(DEPTH));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        store_d   = store_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        w_mem_we  = 1'b0;
        w_load_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_req && !flush) begin
                    if (w_valid) begin
                        store_d = mem_write;
                        idx_d   = addr[IDX_W+2:3];
                        wdata_d = write_data;
                        cnt_d   = 4'(LATENCY - 1);
                        err_d   = 1'b0;
                        state_d = S_BUSY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                // A store is already committed, so only loads may be aborted.
                if (flush && !store_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d   = S_DONE;
                    w_mem_we  = store_q;
                    w_load_en = !store_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            store_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 64'd0;
            err_q       <= 1'b0;
            read_data_q <= 64'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < 8) ? w_elem[i[2:0]] : 64'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            if (w_mem_we) begin
                mem_q[idx_q] <= wdata_q;
            end
            if (w_load_en) begin
                read_data_q <= mem_q[idx_q];
            end
        end
    end

    assign read_data  = read_data_q;
    assign resp_valid = (state_q == S_DONE);
    assign err        = (state_q == S_DONE) & err_q;
    assign stall      = (state_q == S_BUSY) |
                        ((state_q == S_IDLE) & w_req & ~flush);

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Scoreboard bench for data_mem_responder against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int D = 64;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] elem [8];
    logic        mem_read, mem_write, flush;
    logic [63:0] addr, write_data;
    logic [63:0] read_data;
    logic        resp_valid, err, stall;

    data_mem_responder #(.DEPTH(D), .LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .element1(elem[0]), .element2(elem[1]), .element3(elem[2]), .element4(elem[3]),
        .element5(elem[4]), .element6(elem[5]), .element7(elem[6]), .element8(elem[7]),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
        .write_data(write_data), .flush(flush),
        .read_data(read_data), .resp_valid(resp_valid), .err(err), .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        e;
        logic [63:0] rd;
        int          at;
        string       name;
    } exp_t;

    exp_t        sbq [$];
    int          checks   = 0;
    int          failures = 0;
    logic        mon_en   = 1'b0;
    logic [63:0] model_mem [D];
    logic [63:0] model_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_valid(input logic rd, input logic wr, input logic [63:0] a);
        return (rd != wr) && (a % 8 == 0) && (a / 8 < D);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) model_mem[i] = (i < 8) ? elem[i] : 64'd0;
        model_rd = 64'd0;
    endtask

    // Monitor: every response pulse must match the oldest expected entry.
    initial begin
        exp_t x;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: actual=resp_valid=1 required=no pending response (cycle %0d)", cyc);
                end else begin
                    x = sbq.pop_front();
                    chk({x.name, "_err"}, {63'd0, err}, {63'd0, x.e});
                    chk({x.name, "_rdata"}, read_data, x.rd);
                    chk({x.name, "_cycle"}, 64'(cyc), 64'(x.at));
                end
            end else if (err !== 1'b0) begin
                chk("err_without_valid", {63'd0, err}, 64'd0);
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [63:0] a,
                         input logic [63:0] d, input logic f);
        mem_read = rd; mem_write = wr; addr = a; write_data = d; flush = f;
    endtask

    // One complete access; fl asserts flush during the first BUSY cycle.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [63:0] a, input logic [63:0] d, input logic fl);
        int  c;
        bit  v, abort;
        @(negedge clk);
        drive(rd, wr, a, d, 1'b0);
        c = cyc;
        v = is_valid(rd, wr, a);
        abort = v && fl && rd;
        #1 chk({name, "_stall_req"}, {63'd0, stall}, 64'd1);
        if (!v) begin
            sbq.push_back('{1'b1, model_rd, c + 1, name});
        end else if (!abort) begin
            if (wr) model_mem[a / 8] = d;
            else    model_rd = model_mem[a / 8];
            sbq.push_back('{1'b0, model_rd, c + L + 1, name});
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 64'd0, 64'd0, fl && v);
        #1;
        if (!v) begin
            chk({name, "_stall_done"}, {63'd0, stall}, 64'd0);
            return;
        end
        if (abort) begin
            chk({name, "_stall_flushbusy"}, {63'd0, stall}, 64'd1);
            @(negedge clk);
            flush = 1'b0;
            #1 chk({name, "_stall_after_flush"}, {63'd0, stall}, 64'd0);
            chk({name, "_rdata_after_flush"}, read_data, model_rd);
            return;
        end
        for (int k = 1; k <= L; k++) begin
            chk({name, "_stall_busy"}, {63'd0, stall}, 64'd1);
            @(negedge clk);
            flush = 1'b0;
            #1;
        end
        chk({name, "_stall_done"}, {63'd0, stall}, 64'd0);
    endtask

    task automatic idle_flush(input logic [63:0] a);
        @(negedge clk);
        drive(1'b1, 1'b0, a, 64'd0, 1'b1);
        #1 chk("idle_flush_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        #1 chk("idle_flush_not_accepted", {63'd0, stall}, 64'd0);
    endtask

    initial begin
        int c;
        int r;
        logic [63:0] a, d;
        logic        rd, wr;

        for (int i = 0; i < 8; i++) elem[i] = 64'(i + 1);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_read_data", read_data, 64'd0);
        chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset_err", {63'd0, err}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;

        access("ld_0x18", 1'b1, 1'b0, 64'h18, 64'd0, 1'b0);
        for (int i = 0; i < 8; i++) access("ld_elem", 1'b1, 1'b0, 64'(8 * i), 64'd0, 1'b0);
        access("sd_0x40", 1'b0, 1'b1, 64'h40, 64'hDEADBEEF, 1'b0);
        access("ld_0x40", 1'b1, 1'b0, 64'h40, 64'd0, 1'b0);
        access("ld_misaligned", 1'b1, 1'b0, 64'h1C, 64'd0, 1'b0);
        access("rd_and_wr", 1'b1, 1'b1, 64'h0, 64'h1234, 1'b0);
        access("ld_out_of_range", 1'b1, 1'b0, 64'(8 * D), 64'd0, 1'b0);
        access("ld_0x0_unchanged", 1'b1, 1'b0, 64'h0, 64'd0, 1'b0);
        access("ld_flushed", 1'b1, 1'b0, 64'h0, 64'd0, 1'b1);
        access("sd_flushed", 1'b0, 1'b1, 64'h0, 64'h55, 1'b1);
        access("ld_0x0_after_sd", 1'b1, 1'b0, 64'h0, 64'd0, 1'b0);
        idle_flush(64'h10);

        // Reset in the middle of a store: the store must never land.
        @(negedge clk);
        drive(1'b0, 1'b1, 64'h8, 64'hFF, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("midreset_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("midreset_err", {63'd0, err}, 64'd0);
        chk("midreset_read_data", read_data, 64'd0);
        chk("midreset_stall", {63'd0, stall}, 64'd0);
        model_reset();
        access("ld_0x8_after_reset", 1'b1, 1'b0, 64'h8, 64'd0, 1'b0);

        // mem_read held through DONE must not start a second access.
        @(negedge clk);
        drive(1'b1, 1'b0, 64'h10, 64'd0, 1'b0);
        c = cyc;
        model_rd = model_mem[2];
        sbq.push_back('{1'b0, model_rd, c + L + 1, "ld_held"});
        repeat (L + 1) @(negedge clk);
        #1 chk("held_stall_done", {63'd0, stall}, 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(negedge clk);
        #1 chk("held_no_second_access", {63'd0, stall}, 64'd0);
        access("ld_reasserted", 1'b1, 1'b0, 64'h18, 64'd0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            a  = 64'(8 * $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = 64'(8 * $urandom_range(0, D - 1));
            d  = {$urandom, $urandom};
            rd = 1'b1; wr = 1'b0;
            case (r)
                0, 1, 2, 3: ;
                4, 5, 6: begin rd = 1'b0; wr = 1'b1; end
                7: begin
                    case ($urandom_range(0, 2))
                        0: a = a | 64'($urandom_range(1, 7));
                        1: begin rd = 1'b1; wr = 1'b1; end
                        default: a = ($urandom_range(0, 1) == 0) ? 64'(8 * (D + $urandom_range(0, 100)))
                                                                 : ({$urandom, $urandom} & ~64'h7) | 64'h8000_0000_0000_0000;
                    endcase
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) begin rd = 1'b0; wr = 1'b1; end
                end
            endcase
            if (r == 9) idle_flush(a);
            else        access("rand", rd, wr, a, d, r == 8);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-stage responder for the 64-bit RISC-V pipeline. It is the target end of the LD/SD request interface.
- Holds a doubleword data memory and services one load or store at a time with a fixed multi-cycle latency.
- Drives `stall` back to the core while an access is in flight and accepts `flush` from the core.
- Words 0..7 are initialised from `element1`..`element8` on reset, so benches can preload operands.

Parameters:
- DEPTH, 64: number of 64-bit doublewords; byte address range 0 .. 8*DEPTH-1.
- LATENCY, 2: cycles spent in BUSY per access; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- element1..element8  in  64 each  reset-time contents of words 0..7.
- mem_read  in  1  load request (LD).
- mem_write  in  1  store request (SD).
- addr  in  64  byte address.
- write_data  in  64  store data.
- flush  in  1  pipeline flush from core.
- read_data  out  64  load result.
- resp_valid  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with resp_valid.
- stall  out  1  hold request from responder to core.

Behaviour:
- Reset (sampled at posedge):
  - state=IDLE; read_data=0; resp_valid=0; err=0.
  - mem[i] = element(i+1) for i=0..7; mem[8..DEPTH-1]=0; latched request cleared.
  - Reset overrides any in-flight access; an aborted store is never written.
- States: IDLE, BUSY, DONE.
- IDLE:
  - A request is present when mem_read|mem_write.
  - A request is valid when exactly one of mem_read/mem_write is high, addr[2:0]==0, and addr[63:3] < DEPTH.
  - Valid request: latch op, addr index, write_data; cnt=LATENCY-1; go to BUSY.
  - Invalid request (both high, misaligned, or out of range): no memory access; go to DONE with err pending.
- BUSY:
  - If cnt!=0, decrement cnt.
  - If cnt==0, go to DONE. On that edge a store writes mem[idx]; a load loads read_data<=mem[idx].
- DONE: resp_valid=1 for exactly this cycle; err=1 here if the request was invalid; next state is IDLE unconditionally.
- Requests seen in DONE are ignored: the core still presents the completed instruction during that cycle.
- stall (combinational) = (state==BUSY) | (state==IDLE & request present). It is low in DONE.
- Latency: a request first seen in cycle 0 has resp_valid/read_data valid in cycle LATENCY+1. Throughput is one access per LATENCY+2 cycles.
- read_data holds its last loaded value until the next completed load. Stores and errors leave it unchanged.
- Flush:
  - In IDLE: suppresses acceptance that cycle, and stall=0 that cycle.
  - In BUSY with a pending load: abort, go to IDLE; no resp_valid, read_data unchanged.
  - In BUSY with a pending store: ignored; the store completes normally (already committed).
  - In DONE: no effect.
- Store then load to the same address returns the new data; there is no forwarding hazard because accesses are serialised.
- No X propagation: outputs are always driven from registers or state.

Test Plan:
- Reset with element1..8 = 1..8, then LD addr=0x18, LATENCY=2 -> stall high cycles 0-2, resp_valid pulse in cycle 3, read_data=0x4, err=0.
- SD addr=0x40 data=0xDEADBEEF, then LD addr=0x40 -> second response read_data=0xDEADBEEF; read_data unchanged (0x4) during the SD's DONE.
- LD addr=0x1C (misaligned); mem_read&mem_write at 0x0; LD addr=8*DEPTH -> each gives one DONE cycle with resp_valid=1, err=1, read_data unchanged, memory unchanged.
- LD addr=0x0 with flush asserted in first BUSY cycle -> returns to IDLE, no resp_valid, stall drops the next cycle. Repeat with SD data=0x55 -> store completes, resp_valid pulses, later LD 0x0 returns 0x55.
- Reset asserted mid-BUSY of SD addr=0x8 data=0xFF -> IDLE next cycle, outputs zero, later LD 0x8 returns element2 (0x2).
- mem_read held high through DONE -> no second access started; next access begins only when mem_read is reasserted in IDLE.
